// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared types and helpers for the ALU multiply path.
//   - mult_state_e : sequencer states IDLE -> CLEAR -> RUN -> DONE
//   - DEF_WIDTH / DEF_MULT_LATENCY : default operand width and core latency
//   - neg2c()      : two's-complement negation truncated to a given width
package alu_pkg;

    localparam int          DEF_WIDTH        = 32;
    localparam int          DEF_MULT_LATENCY = 33;
    // Working width of neg2c(); callers cast in and out of this width.
    localparam int unsigned NEG2C_W          = 128;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        RUN,
        DONE
    } mult_state_e;

    // Negates 'value' and keeps only the low 'width' bits, so the result
    // is the two's-complement negation of a width-bit quantity.
    function automatic logic [NEG2C_W-1:0] neg2c(input logic [NEG2C_W-1:0] value,
                                                 input int unsigned        width);
        logic [NEG2C_W-1:0] mask;
        if (width >= NEG2C_W) begin
            mask = '1;
        end else begin
            mask = (NEG2C_W'(1) << width) - NEG2C_W'(1);
        end
        return (~value + NEG2C_W'(1)) & mask;
    endfunction

endpackage

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl
//   Issue/capture sequencer around an external shift-add multiplier core.
//   Accepts one operand pair per in_valid/in_ready handshake, loads it into
//   the core while holding the core in clear for one cycle, counts the core
//   latency, captures the product and presents it on out_valid/out_ready
//   until consumed. Only one product is in flight at a time.
//
//   Ports
//     clk, rst             clock, asynchronous active-high reset
//     in_valid/in_ready    upstream operand handshake
//     in_a, in_b           operands (WIDTH bits)
//     in_signed            two's-complement operands (signed build only)
//     mult_a, mult_b       operands to the core, stable through the run
//     mult_clr             core reset, high clears the core
//     mult_result          product from the core (2*WIDTH bits)
//     out_valid/out_ready  downstream product handshake
//     out_result           captured product
//     out_zero             out_result == 0, meaningful while out_valid
//
//   Build option
//     SIGNED_MULT_EN : when defined, in_signed=1 makes the block multiply
//                      magnitudes and negate the captured product when the
//                      operand signs differ. Undefined: unsigned only.
module mult_seq_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int MULT_LATENCY = DEF_MULT_LATENCY,
    parameter int CNT_W        = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_signed,
    output logic [WIDTH-1:0]     mult_a,
    output logic [WIDTH-1:0]     mult_b,
    output logic                 mult_clr,
    input  logic [2*WIDTH-1:0]   mult_result,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_result,
    output logic                 out_zero
);

    mult_state_e         state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [WIDTH-1:0]    mult_a_q;
    logic [WIDTH-1:0]    mult_b_q;
    logic                mult_clr_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic [2*WIDTH-1:0]  out_result_q;
    logic                out_zero_q;

    logic [WIDTH-1:0]    op_a_d;
    logic [WIDTH-1:0]    op_b_d;
    logic [2*WIDTH-1:0]  prod_d;

`ifdef SIGNED_MULT_EN
    logic neg_d;
    logic neg_q;

    // The core is unsigned: feed it magnitudes and remember whether the
    // true product is negative so the capture can restore the sign.
    always_comb begin
        op_a_d = in_a;
        op_b_d = in_b;
        neg_d  = 1'b0;
        if (in_signed) begin
            if (in_a[WIDTH-1]) begin
                op_a_d = WIDTH'(neg2c(NEG2C_W'(in_a), WIDTH));
            end
            if (in_b[WIDTH-1]) begin
                op_b_d = WIDTH'(neg2c(NEG2C_W'(in_b), WIDTH));
            end
            neg_d = in_a[WIDTH-1] ^ in_b[WIDTH-1];
        end
        prod_d = neg_q ? (2*WIDTH)'(neg2c(NEG2C_W'(mult_result), 2*WIDTH))
                       : mult_result;
    end
`else
    logic unused_in_signed;
    assign unused_in_signed = in_signed;

    // Unsigned build: operands and product pass straight through.
    always_comb begin
        op_a_d = in_a;
        op_b_d = in_b;
        prod_d = mult_result;
    end
`endif

    // Sequencer. Every output is a register so the core and downstream
    // logic never see combinational glitches from the handshake inputs.
    // RUN lasts MULT_LATENCY cycles (counter MULT_LATENCY-1 down to 0) and
    // the product is captured on the last of them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            mult_a_q     <= '0;
            mult_b_q     <= '0;
            mult_clr_q   <= 1'b1;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_zero_q   <= 1'b0;
`ifdef SIGNED_MULT_EN
            neg_q        <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    mult_clr_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        mult_a_q   <= op_a_d;
                        mult_b_q   <= op_b_d;
`ifdef SIGNED_MULT_EN
                        neg_q      <= neg_d;
`endif
                        in_ready_q <= 1'b0;
                        state_q    <= CLEAR;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    cnt_q      <= CNT_W'(MULT_LATENCY - 1);
                    mult_clr_q <= 1'b0;
                    state_q    <= RUN;
                end
                RUN: begin
                    if (cnt_q == '0) begin
                        out_result_q <= prod_d;
                        out_zero_q   <= (prod_d == '0);
                        out_valid_q  <= 1'b1;
                        state_q      <= DONE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                DONE: begin
                    // in_ready rises only once back in IDLE, so a pair held
                    // on in_valid is taken on the IDLE cycle, never here.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        mult_clr_q  <= 1'b1;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign mult_a     = mult_a_q;
    assign mult_b     = mult_b_q;
    assign mult_clr   = mult_clr_q;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_zero   = out_zero_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb_mult_seq_ctrl
//   Bench for mult_seq_ctrl. A behavioural multiplier core answers the
//   DUT's mult_a/mult_b/mult_clr, and a transaction-level model predicts
//   every product and the handshake timing. Cycle numbering: the cycle in
//   which a pair is accepted is cycle 0; out_valid is due in cycle LAT+2
//   and the next pair can be accepted in cycle LAT+3.
module tb_mult_seq_ctrl;

    localparam int          WIDTH = 32;
    localparam int          LAT   = 33;
    localparam int          CNT_W = 6;
    localparam logic [63:0] JUNK  = 64'hA5A5_0000_0000_5A5A;
`ifdef SIGNED_MULT_EN
    localparam bit SIGNED_BUILD = 1'b1;
`else
    localparam bit SIGNED_BUILD = 1'b0;
`endif

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        in_valid  = 1'b0;
    logic        in_signed = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_a      = '0;
    logic [31:0] in_b      = '0;
    logic        in_ready;
    logic [31:0] mult_a;
    logic [31:0] mult_b;
    logic        mult_clr;
    logic [63:0] mult_result;
    logic        out_valid;
    logic [63:0] out_result;
    logic        out_zero;

    int checks = 0;
    int errors = 0;

    mult_seq_ctrl #(
        .WIDTH        (WIDTH),
        .MULT_LATENCY (LAT),
        .CNT_W        (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_signed   (in_signed),
        .mult_a      (mult_a),
        .mult_b      (mult_b),
        .mult_clr    (mult_clr),
        .mult_result (mult_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_zero    (out_zero)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Expected product from the operand values alone.
    function automatic longint unsigned refProduct(input logic [31:0] a,
                                                   input logic [31:0] b,
                                                   input logic s);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        if (SIGNED_BUILD && s) begin
            sa = $signed(a);
            sb = $signed(b);
            return sa * sb;
        end
        ua = {32'b0, a};
        ub = {32'b0, b};
        return ua * ub;
    endfunction

    // Operand value the core must be given: its magnitude when signed.
    function automatic logic [31:0] refMag(input logic [31:0] a, input logic s);
        logic [31:0] r;
        r = a;
        if (SIGNED_BUILD && s && a[31]) r = ~a + 32'd1;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural core: the product is only right once the core has been
    // out of clear for LAT cycles; before that it returns a corrupted value
    // so an early capture shows up as a wrong result.
    int lowEdges = 0;
    always @(posedge clk or posedge rst) begin
        if (rst || mult_clr) lowEdges <= 0;
        else                 lowEdges <= lowEdges + 1;
    end

    always_comb begin
        mult_result = 64'(mult_a) * 64'(mult_b);
        if (mult_clr || lowEdges < LAT - 1) mult_result = mult_result ^ JUNK;
    end

    // Transaction model: one pair in flight; accept when ready, product due
    // LAT+1 edges after the accept edge, retired on out_ready.
    longint unsigned expQ[$];
    int              edgeCount = 0;
    int              acceptAt  = 0;
    int              doneCount = 0;
    bit              busy      = 1'b0;
    bit              readyExp  = 1'b0;
    logic [31:0]     expA      = '0;
    logic [31:0]     expB      = '0;

    always @(posedge clk) edgeCount <= edgeCount + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= 1'b0;
            readyExp <= 1'b0;
            expQ.delete();
        end else if (!busy) begin
            if (in_valid && readyExp) begin
                expQ.push_back(refProduct(in_a, in_b, in_signed));
                expA     <= refMag(in_a, in_signed);
                expB     <= refMag(in_b, in_signed);
                acceptAt <= edgeCount;
                busy     <= 1'b1;
                readyExp <= 1'b0;
            end else begin
                readyExp <= 1'b1;
            end
        end else if (edgeCount >= acceptAt + LAT + 2 && out_ready) begin
            void'(expQ.pop_front());
            busy      <= 1'b0;
            readyExp  <= 1'b1;
            doneCount <= doneCount + 1;
        end
    end

    // Compare the DUT against the model on every falling edge out of reset.
    always @(negedge clk) begin
        if (!rst) begin
            bit expValid;
            expValid = busy && (edgeCount >= acceptAt + LAT + 2);
            checkOutput("out_valid", out_valid, expValid);
            checkOutput("in_ready", in_ready, readyExp);
            if (expValid) begin
                checkOutput("out_result", out_result, expQ[0]);
                checkOutput("out_zero", out_zero, expQ[0] == 0);
            end
            if (!busy || edgeCount == acceptAt + 1) begin
                checkOutput("mult_clr high", mult_clr, 1'b1);
            end else if (edgeCount <= acceptAt + LAT + 1) begin
                checkOutput("mult_clr run", mult_clr, 1'b0);
            end
            if (busy && edgeCount <= acceptAt + LAT + 1) begin
                checkOutput("mult_a", mult_a, expA);
                checkOutput("mult_b", mult_b, expB);
            end
        end
    end

    // One directed transaction: accept, measure latency, hold off
    // out_ready for holdCycles, then release.
    task automatic applyStimulus(input string name, input logic [31:0] a,
                                 input logic [31:0] b, input logic s,
                                 input int holdCycles, input logic [63:0] expLit);
        int cyc;
        @(negedge clk);
        in_a = a; in_b = b; in_signed = s; in_valid = 1'b1; out_ready = 1'b0;
        cyc = 0;
        while (in_ready !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (in_ready !== 1'b1) begin
            checkOutput({name, " accept timeout"}, in_ready, 1'b1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        in_a      = $urandom;
        in_b      = $urandom;
        in_signed = 1'($urandom_range(0, 1));
        cyc = 1;
        while (out_valid !== 1'b1 && cyc < LAT + 20) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput({name, " latency"}, cyc, LAT + 2);
        checkOutput({name, " result"}, out_result, expLit);
        checkOutput({name, " zero"}, out_zero, expLit == 0);
        for (int i = 0; i < holdCycles; i++) begin
            @(negedge clk);
            checkOutput({name, " held"}, out_result, expLit);
            checkOutput({name, " in_ready low"}, in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput({name, " released"}, out_valid, 1'b0);
        out_ready = 1'b0;
    endtask

    // Start a product and hit reset mid-RUN or mid-DONE.
    task automatic resetMidFlight(input string name, input bit inDone);
        int cyc;
        @(negedge clk);
        in_a = 32'd9; in_b = 32'd9; in_signed = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        cyc = 0;
        while (in_ready !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        if (inDone) begin
            cyc = 1;
            while (out_valid !== 1'b1 && cyc < LAT + 20) begin
                @(negedge clk);
                cyc++;
            end
            checkOutput({name, " reached done"}, out_valid, 1'b1);
        end else begin
            repeat (10) @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        checkOutput({name, " out_valid"}, out_valid, 1'b0);
        checkOutput({name, " mult_clr"}, mult_clr, 1'b1);
        checkOutput({name, " in_ready"}, in_ready, 1'b0);
        checkOutput({name, " out_result"}, out_result, 64'd0);
        @(negedge clk);
        checkOutput({name, " out_valid held"}, out_valid, 1'b0);
        checkOutput({name, " in_ready held"}, in_ready, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput({name, " ready after"}, in_ready, 1'b1);
    endtask

    // Hard stop in case something upstream never returns.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed tests, then randomized traffic, then the summary.
    initial begin
        int cyc;
        int startDone;
        bit sawFirst;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset in_ready", in_ready, 1'b0);
        checkOutput("reset out_valid", out_valid, 1'b0);
        checkOutput("reset mult_clr", mult_clr, 1'b1);
        checkOutput("reset out_result", out_result, 64'd0);
        checkOutput("reset out_zero", out_zero, 1'b0);
        checkOutput("reset mult_a", mult_a, 32'd0);
        checkOutput("reset mult_b", mult_b, 32'd0);
        rst = 1'b0;

        checkOutput("model 7x6", refProduct(32'd7, 32'd6, 1'b0), 64'd42);
        checkOutput("model ones", refProduct(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0),
                    64'hFFFFFFFE00000001);
        checkOutput("model -3x5", refProduct(32'hFFFFFFFD, 32'd5, 1'b1),
                    SIGNED_BUILD ? 64'hFFFFFFFFFFFFFFF1 : 64'h4FFFFFFF1);

        applyStimulus("t1 7x6", 32'd7, 32'd6, 1'b0, 0, 64'd42);
        applyStimulus("t2 zero", 32'd0, 32'hFFFFFFFF, 1'b0, 0, 64'd0);
        applyStimulus("t3 backpressure", 32'd123456789, 32'd987, 1'b0, 10, 64'd121851850743);
        applyStimulus("ones", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 2, 64'hFFFFFFFE00000001);
        applyStimulus("t5 signed", 32'hFFFFFFFD, 32'd5, 1'b1, 1,
                      SIGNED_BUILD ? 64'hFFFFFFFFFFFFFFF1 : 64'h4FFFFFFF1);

        resetMidFlight("t4 rst run", 1'b0);
        applyStimulus("t4 after run", 32'h12345678, 32'h10, 1'b0, 0, 64'h123456780);
        resetMidFlight("rst done", 1'b1);
        applyStimulus("after done", 32'd1000, 32'd1000, 1'b0, 0, 64'd1000000);

        // Back-to-back: in_valid stays high across both pairs.
        @(negedge clk);
        in_a = 32'd11; in_b = 32'd13; in_signed = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        cyc = 0;
        while (in_ready !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        @(posedge clk);
        @(negedge clk);
        in_a = 32'd100; in_b = 32'd200;
        cyc = 1;
        sawFirst = 1'b0;
        while (in_ready !== 1'b1 && cyc < LAT + 20) begin
            if (out_valid === 1'b1) begin
                checkOutput("t6 first result", out_result, 64'd143);
                sawFirst = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        checkOutput("t6 first seen", sawFirst, 1'b1);
        checkOutput("t6 second accept cycle", cyc, LAT + 3);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1;
        while (out_valid !== 1'b1 && cyc < LAT + 20) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("t6 second latency", cyc, LAT + 2);
        checkOutput("t6 second result", out_result, 64'd20000);
        @(negedge clk);
        out_ready = 1'b0;

        // Randomized traffic with corner-biased operands and random stalls.
        startDone = doneCount;
        cyc = 0;
        while (doneCount < startDone + 30 && cyc < 8000) begin
            @(negedge clk);
            case ($urandom_range(0, 5))
                0:       in_a = 32'd0;
                1:       in_a = 32'hFFFFFFFF;
                2:       in_a = 32'h80000000;
                default: in_a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       in_b = 32'd0;
                1:       in_b = 32'hFFFFFFFF;
                2:       in_b = 32'h7FFFFFFF;
                default: in_b = $urandom;
            endcase
            in_signed = 1'($urandom_range(0, 1));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 1));
            cyc++;
        end
        checkOutput("random products retired", 64'(doneCount - startDone >= 30), 64'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (LAT + 6) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
